boneless_boot_loader: RTL and testbench

Boot controller for the Boneless CPU: it sequences CPU reset and owns the CPU's main memory ports until a program image is loaded. While the CPU is held in reset, it accepts a framed image (count, payload, checksum) over a valid/ready word stream and writes the payload into main memory. On a good checksum it hands the memory ports to the CPU and releases `cpu_rst`. It sits between the `boneless` core and the main memory array, in place of a direct connection.

---
 rtl/boneless_boot_pkg.sv | 14 +
 rtl/boneless_boot_mux.sv | 40 ++++
 rtl/boneless_boot_loader.sv | 127 ++++++++++++
 tb/tb_boneless_boot_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boneless_boot_pkg.sv
// Shared types and constants for the Boneless boot loader.
package boneless_boot_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CSUM,
    RUN,
    ERR
  } boot_state_t;

endpackage

// File: rtl/boneless_boot_mux.sv
// Main-memory port steering: the CPU owns the ports in RUN, the loader otherwise.
module boneless_boot_mux
  import boneless_boot_pkg::*;
(
  input  logic              run,
  input  logic [WORD_W-1:0] cpu_mem_r_addr,
  input  logic              cpu_mem_r_en,
  output logic [WORD_W-1:0] cpu_mem_r_data,
  input  logic [WORD_W-1:0] cpu_mem_w_addr,
  input  logic [WORD_W-1:0] cpu_mem_w_data,
  input  logic              cpu_mem_w_en,
  input  logic [WORD_W-1:0] ld_w_addr,
  input  logic [WORD_W-1:0] ld_w_data,
  input  logic              ld_w_en,
  output logic [WORD_W-1:0] mem_r_addr,
  output logic              mem_r_en,
  input  logic [WORD_W-1:0] mem_r_data,
  output logic [WORD_W-1:0] mem_w_addr,
  output logic [WORD_W-1:0] mem_w_data,
  output logic              mem_w_en
);

  // The loader never reads, so the read port is idle outside RUN.
  always_comb begin
    cpu_mem_r_data = mem_r_data;
    mem_r_addr     = '0;
    mem_r_en       = 1'b0;
    mem_w_addr     = ld_w_addr;
    mem_w_data     = ld_w_data;
    mem_w_en       = ld_w_en;
    if (run) begin
      mem_r_addr = cpu_mem_r_addr;
      mem_r_en   = cpu_mem_r_en;
      mem_w_addr = cpu_mem_w_addr;
      mem_w_data = cpu_mem_w_data;
      mem_w_en   = cpu_mem_w_en;
    end
  end

endmodule

// File: rtl/boneless_boot_loader.sv
// Boot controller: holds the Boneless CPU in reset while a framed image
// (count, payload, checksum) is streamed into main memory, then releases it.
module boneless_boot_loader
  import boneless_boot_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reboot,
  input  logic [WORD_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              cpu_rst,
  input  logic [WORD_W-1:0] cpu_mem_r_addr,
  input  logic              cpu_mem_r_en,
  output logic [WORD_W-1:0] cpu_mem_r_data,
  input  logic [WORD_W-1:0] cpu_mem_w_addr,
  input  logic [WORD_W-1:0] cpu_mem_w_data,
  input  logic              cpu_mem_w_en,
  output logic [WORD_W-1:0] mem_r_addr,
  output logic              mem_r_en,
  input  logic [WORD_W-1:0] mem_r_data,
  output logic [WORD_W-1:0] mem_w_addr,
  output logic [WORD_W-1:0] mem_w_data,
  output logic              mem_w_en,
  output logic              boot_done,
  output logic              boot_err,
  output logic [WORD_W-1:0] words_loaded
);

  boot_state_t       state, state_next;
  logic [WORD_W-1:0] count, count_next;
  logic [WORD_W-1:0] index, index_next;
  logic [WORD_W-1:0] sum, sum_next;
  logic [WORD_W-1:0] words_loaded_next;
  logic              acc;
  logic              ld_w_en;
  logic [WORD_W-1:0] ld_w_addr;

  // Reboot blocks the stream in its cycle so a presented word is kept, not lost.
  assign src_ready = ((state == HDR) || (state == LOAD) || (state == CSUM)) && !reboot && !rst;
  assign acc       = src_valid && src_ready;
  assign cpu_rst   = (state != RUN);
  assign boot_done = (state == RUN);
  assign boot_err  = (state == ERR);
  assign ld_w_addr = BASE_ADDR + index;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR;
      count        <= '0;
      index        <= '0;
      sum          <= '0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      index        <= index_next;
      sum          <= sum_next;
      words_loaded <= words_loaded_next;
    end
  end

  always_comb begin
    state_next        = state;
    count_next        = count;
    index_next        = index;
    sum_next          = sum;
    words_loaded_next = words_loaded;
    ld_w_en           = 1'b0;
    if (reboot) begin
      state_next        = HDR;
      index_next        = '0;
      sum_next          = '0;
      words_loaded_next = '0;
    end else begin
      unique case (state)
        HDR: if (acc) begin
          count_next        = src_data;
          index_next        = '0;
          sum_next          = '0;
          words_loaded_next = '0;
          if (src_data == '0)
            state_next = CSUM;
          else if (32'(src_data) > MAX_WORDS)
            state_next = ERR;
          else
            state_next = LOAD;
        end
        LOAD: if (acc) begin
          ld_w_en           = 1'b1;
          sum_next          = sum + src_data;
          index_next        = index + 1'b1;
          words_loaded_next = words_loaded + 1'b1;
          if (index == count - 1'b1)
            state_next = CSUM;
        end
        CSUM: if (acc) begin
          state_next = (src_data == sum) ? RUN : ERR;
        end
        default: ;
      endcase
    end
  end

  boneless_boot_mux u_mux (
    .run            (state == RUN),
    .cpu_mem_r_addr (cpu_mem_r_addr),
    .cpu_mem_r_en   (cpu_mem_r_en),
    .cpu_mem_r_data (cpu_mem_r_data),
    .cpu_mem_w_addr (cpu_mem_w_addr),
    .cpu_mem_w_data (cpu_mem_w_data),
    .cpu_mem_w_en   (cpu_mem_w_en),
    .ld_w_addr      (ld_w_addr),
    .ld_w_data      (src_data),
    .ld_w_en        (ld_w_en),
    .mem_r_addr     (mem_r_addr),
    .mem_r_en       (mem_r_en),
    .mem_r_data     (mem_r_data),
    .mem_w_addr     (mem_w_addr),
    .mem_w_data     (mem_w_data),
    .mem_w_en       (mem_w_en)
  );

endmodule

// File: tb/tb_boneless_boot_loader.sv
// Directed bench for boneless_boot_loader: a BASE 0x0100 instance with a memory
// model, plus a BASE 0xFFFF instance on the same stream for address wrap.
module tb_boneless_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reboot = 1'b0;
  logic [15:0] src_data = 16'h0000;
  logic        src_valid = 1'b0;
  logic [15:0] cpu_mem_r_addr = 16'h0000;
  logic        cpu_mem_r_en = 1'b0;
  logic [15:0] cpu_mem_w_addr = 16'h0000;
  logic [15:0] cpu_mem_w_data = 16'h0000;
  logic        cpu_mem_w_en = 1'b0;

  logic        src_ready, cpu_rst, boot_done, boot_err;
  logic [15:0] cpu_mem_r_data, mem_r_addr, mem_w_addr, mem_w_data, words_loaded;
  logic        mem_r_en, mem_w_en;
  logic [15:0] mem_r_data = 16'h0000;

  logic        w_src_ready, w_cpu_rst, w_boot_done, w_boot_err;
  logic [15:0] w_cpu_mem_r_data, w_mem_r_addr, w_mem_w_addr, w_mem_w_data, w_words_loaded;
  logic        w_mem_r_en, w_mem_w_en;
  logic [15:0] w_mem_r_data = 16'h0000;

  logic [15:0] mem_model [0:65535];
  int          wr_count = 0;
  int          snap = 0;
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Main memory with one cycle of registered read latency; also counts writes.
  always @(posedge clk) begin
    if (mem_w_en === 1'b1) begin
      mem_model[mem_w_addr] <= mem_w_data;
      wr_count <= wr_count + 1;
    end
    if (mem_r_en === 1'b1) mem_r_data <= mem_model[mem_r_addr];
  end

  boneless_boot_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .reboot(reboot), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .cpu_rst(cpu_rst),
    .cpu_mem_r_addr(cpu_mem_r_addr), .cpu_mem_r_en(cpu_mem_r_en), .cpu_mem_r_data(cpu_mem_r_data),
    .cpu_mem_w_addr(cpu_mem_w_addr), .cpu_mem_w_data(cpu_mem_w_data), .cpu_mem_w_en(cpu_mem_w_en),
    .mem_r_addr(mem_r_addr), .mem_r_en(mem_r_en), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .boot_done(boot_done), .boot_err(boot_err), .words_loaded(words_loaded)
  );

  boneless_boot_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(1024)) dut_wrap (
    .clk(clk), .rst(rst), .reboot(reboot), .src_data(src_data), .src_valid(src_valid),
    .src_ready(w_src_ready), .cpu_rst(w_cpu_rst),
    .cpu_mem_r_addr(cpu_mem_r_addr), .cpu_mem_r_en(cpu_mem_r_en), .cpu_mem_r_data(w_cpu_mem_r_data),
    .cpu_mem_w_addr(cpu_mem_w_addr), .cpu_mem_w_data(cpu_mem_w_data), .cpu_mem_w_en(cpu_mem_w_en),
    .mem_r_addr(w_mem_r_addr), .mem_r_en(w_mem_r_en), .mem_r_data(w_mem_r_data),
    .mem_w_addr(w_mem_w_addr), .mem_w_data(w_mem_w_data), .mem_w_en(w_mem_w_en),
    .boot_done(w_boot_done), .boot_err(w_boot_err), .words_loaded(w_words_loaded)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rb);
    src_valid = v;
    src_data  = d;
    reboot    = rb;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one word after 0..2 idle cycles and lets it be accepted.
  task automatic sendGapped(input logic [15:0] d);
    repeat ($urandom_range(0, 2)) begin
      applyStimulus(1'b0, 16'h0000, 1'b0);
      tick();
    end
    applyStimulus(1'b1, d, 1'b0);
    checkOutput("gap_src_ready", 16'(src_ready), 16'h1);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    applyStimulus(1'b1, 16'h0003, 1'b0);
    tick();
    tick();
    checkOutput("rst_src_ready", 16'(src_ready), 16'h0);
    checkOutput("rst_cpu_rst", 16'(cpu_rst), 16'h1);
    checkOutput("rst_boot_done", 16'(boot_done), 16'h0);
    checkOutput("rst_boot_err", 16'(boot_err), 16'h0);
    checkOutput("rst_words_loaded", words_loaded, 16'h0000);
    checkOutput("rst_mem_w_en", 16'(mem_w_en), 16'h0);
    checkOutput("rst_mem_r_en", 16'(mem_r_en), 16'h0);
    rst = 1'b0;

    // Good image {3, 1111, 2222, 3333, 6666}, valid held high
    applyStimulus(1'b1, 16'h0003, 1'b0);
    checkOutput("hdr_src_ready", 16'(src_ready), 16'h1);
    checkOutput("hdr_no_write", 16'(mem_w_en), 16'h0);
    tick();
    applyStimulus(1'b1, 16'h1111, 1'b0);
    checkOutput("p0_w_en", 16'(mem_w_en), 16'h1);
    checkOutput("p0_w_addr", mem_w_addr, 16'h0100);
    checkOutput("p0_w_data", mem_w_data, 16'h1111);
    checkOutput("p0_wrap_addr", w_mem_w_addr, 16'hFFFF);
    tick();
    applyStimulus(1'b1, 16'h2222, 1'b0);
    checkOutput("p1_w_addr", mem_w_addr, 16'h0101);
    checkOutput("p1_wrap_addr", w_mem_w_addr, 16'h0000);
    tick();
    applyStimulus(1'b1, 16'h3333, 1'b0);
    checkOutput("p2_w_addr", mem_w_addr, 16'h0102);
    checkOutput("p2_words_loaded", words_loaded, 16'h0002);
    tick();
    applyStimulus(1'b1, 16'h6666, 1'b0);
    checkOutput("csum_no_write", 16'(mem_w_en), 16'h0);
    checkOutput("csum_cpu_rst", 16'(cpu_rst), 16'h1);
    tick();
    applyStimulus(1'b1, 16'h1234, 1'b0);
    checkOutput("run_cpu_rst", 16'(cpu_rst), 16'h0);
    checkOutput("run_boot_done", 16'(boot_done), 16'h1);
    checkOutput("run_src_ready", 16'(src_ready), 16'h0);
    checkOutput("run_words_loaded", words_loaded, 16'h0003);
    checkOutput("mem_0100", mem_model[16'h0100], 16'h1111);
    checkOutput("mem_0101", mem_model[16'h0101], 16'h2222);
    checkOutput("mem_0102", mem_model[16'h0102], 16'h3333);

    // CPU owns memory in RUN: write BEEF to 0x0010 then read it back
    cpu_mem_w_addr = 16'h0010;
    cpu_mem_w_data = 16'hBEEF;
    cpu_mem_w_en   = 1'b1;
    #1;
    checkOutput("cpu_w_en", 16'(mem_w_en), 16'h1);
    checkOutput("cpu_w_addr", mem_w_addr, 16'h0010);
    checkOutput("cpu_w_data", mem_w_data, 16'hBEEF);
    tick();
    cpu_mem_w_en   = 1'b0;
    cpu_mem_r_addr = 16'h0010;
    cpu_mem_r_en   = 1'b1;
    #1;
    checkOutput("cpu_r_en", 16'(mem_r_en), 16'h1);
    checkOutput("cpu_r_addr", mem_r_addr, 16'h0010);
    tick();
    cpu_mem_r_en = 1'b0;
    #1;
    checkOutput("cpu_r_data", cpu_mem_r_data, 16'hBEEF);

    // Reboot from RUN with a CPU write in flight; the stalled word stays unconsumed
    cpu_mem_w_addr = 16'h0011;
    cpu_mem_w_data = 16'hCAFE;
    cpu_mem_w_en   = 1'b1;
    applyStimulus(1'b1, 16'h1234, 1'b1);
    checkOutput("rb_run_src_ready", 16'(src_ready), 16'h0);
    checkOutput("rb_inflight_w_en", 16'(mem_w_en), 16'h1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("rb_cpu_rst", 16'(cpu_rst), 16'h1);
    checkOutput("rb_boot_done", 16'(boot_done), 16'h0);
    checkOutput("rb_cpu_w_blocked", 16'(mem_w_en), 16'h0);
    checkOutput("rb_words_loaded", words_loaded, 16'h0000);
    checkOutput("mem_0011", mem_model[16'h0011], 16'hCAFE);
    cpu_mem_w_en = 1'b0;

    // Bad checksum {3, 1111, 2222, 3333, 6667}
    foreach (mem_model[i]) if (i < 0) mem_model[i] = 16'h0000;
    applyStimulus(1'b1, 16'h0003, 1'b0); tick();
    applyStimulus(1'b1, 16'h1111, 1'b0); tick();
    applyStimulus(1'b1, 16'h2222, 1'b0); tick();
    applyStimulus(1'b1, 16'h3333, 1'b0); tick();
    snap = wr_count;
    applyStimulus(1'b1, 16'h6667, 1'b0); tick();
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("err_boot_err", 16'(boot_err), 16'h1);
    checkOutput("err_cpu_rst", 16'(cpu_rst), 16'h1);
    checkOutput("err_src_ready", 16'(src_ready), 16'h0);
    checkOutput("err_words_loaded", words_loaded, 16'h0003);
    tick();
    tick();
    checkOutput("err_no_writes", 16'(wr_count - snap), 16'h0000);

    // Oversized header 0xFFFF goes straight to ERR with no writes
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    checkOutput("rb_err_src_ready", 16'(src_ready), 16'h0);
    tick();
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    checkOutput("big_hdr_src_ready", 16'(src_ready), 16'h1);
    checkOutput("big_hdr_boot_err_pre", 16'(boot_err), 16'h0);
    snap = wr_count;
    tick();
    applyStimulus(1'b1, 16'h1111, 1'b0);
    checkOutput("big_hdr_boot_err", 16'(boot_err), 16'h1);
    tick();
    checkOutput("big_hdr_no_writes", 16'(wr_count - snap), 16'h0000);

    // Wrap image {2, AAAA, 5555, FFFF} on the BASE 0xFFFF instance
    applyStimulus(1'b0, 16'h0000, 1'b1); tick();
    applyStimulus(1'b1, 16'h0002, 1'b0); tick();
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    checkOutput("wrap0_w_en", 16'(w_mem_w_en), 16'h1);
    checkOutput("wrap0_w_addr", w_mem_w_addr, 16'hFFFF);
    checkOutput("wrap0_w_data", w_mem_w_data, 16'hAAAA);
    tick();
    applyStimulus(1'b1, 16'h5555, 1'b0);
    checkOutput("wrap1_w_addr", w_mem_w_addr, 16'h0000);
    checkOutput("wrap1_w_data", w_mem_w_data, 16'h5555);
    tick();
    applyStimulus(1'b1, 16'hFFFF, 1'b0); tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("wrap_boot_done", 16'(w_boot_done), 16'h1);
    checkOutput("wrap_cpu_rst", 16'(w_cpu_rst), 16'h0);
    checkOutput("wrap_words_loaded", w_words_loaded, 16'h0002);

    // Gapped payload, reboot after payload word 1, then a full gapped image
    applyStimulus(1'b0, 16'h0000, 1'b1); tick();
    sendGapped(16'h0004);
    sendGapped(16'h0001);
    sendGapped(16'h0002);
    applyStimulus(1'b1, 16'h0003, 1'b0);
    checkOutput("gap_words_loaded", words_loaded, 16'h0002);
    applyStimulus(1'b1, 16'h0003, 1'b1);
    checkOutput("gap_rb_src_ready", 16'(src_ready), 16'h0);
    checkOutput("gap_rb_no_write", 16'(mem_w_en), 16'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("gap_rb_words_loaded", words_loaded, 16'h0000);
    checkOutput("gap_rb_cpu_rst", 16'(cpu_rst), 16'h1);
    sendGapped(16'h0002);
    sendGapped(16'h0100);
    sendGapped(16'h0200);
    sendGapped(16'h0300);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("gap_boot_done", 16'(boot_done), 16'h1);
    checkOutput("gap_words_final", words_loaded, 16'h0002);
    checkOutput("gap_mem_0100", mem_model[16'h0100], 16'h0100);
    checkOutput("gap_mem_0101", mem_model[16'h0101], 16'h0200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
